uq_sumsq_accum: RTL

- Downstream consumer of the combinational 16x16 DSP multiplier in the uncertainty-propagation datapath.
- Registers each 32-bit product and accumulates a set of products (e.g. (df/dx_i * sigma_i)^2 terms) into a saturating signed accumulator.
- When the set ends, presents the sum, the term count and an overflow flag to the next stage over a valid/ready handshake.

---
 rtl/uq_sumsq_accum_if.sv | 28 ++
 rtl/uq_sumsq_accum.sv | 116 +++++++++++
 2 files changed

// File: rtl/uq_sumsq_accum_if.sv
// Product-in / result-out handshake bundle for the sum-of-squares accumulator.
// The slave modport is the accumulator's side; the master modport is the producer/consumer side.
interface uq_sumsq_accum_if #(
    parameter int ACC_W = 40,
    parameter int CNT_W = 8
);
    logic [31:0]      P_IN;
    logic             P_SIGNED;
    logic             P_VALID;
    logic             P_LAST;
    logic             P_READY;
    logic             CLR;
    logic [ACC_W-1:0] SUM;
    logic [CNT_W-1:0] SUM_COUNT;
    logic             SUM_OVF;
    logic             SUM_VALID;
    logic             SUM_READY;

    modport slave (
        input  P_IN, P_SIGNED, P_VALID, P_LAST, CLR, SUM_READY,
        output P_READY, SUM, SUM_COUNT, SUM_OVF, SUM_VALID
    );

    modport master (
        output P_IN, P_SIGNED, P_VALID, P_LAST, CLR, SUM_READY,
        input  P_READY, SUM, SUM_COUNT, SUM_OVF, SUM_VALID
    );
endinterface

// File: rtl/uq_sumsq_accum.sv
// Two-stage saturating accumulator for multiplier products: stage 1 registers the extended
// product, stage 2 adds it into a signed accumulator; the finished set is offered over valid/ready.
module uq_sumsq_accum #(
    parameter int ACC_W = 40,
    parameter int CNT_W = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    uq_sumsq_accum_if.slave  bus
);
    typedef enum logic [1:0] {ACCUM, FLUSH, DONE} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic [ACC_W-1:0] s1_q, s1_d;
    logic             s1_last_q, s1_last_d;
    logic             s1_v_q, s1_v_d;

    logic             p_ready;
    logic             accept;
    logic [ACC_W-1:0] p_ext;
    logic [ACC_W:0]   sum_wide;

    always_comb begin
        p_ready   = (state_q == ACCUM) && !bus.CLR;
        accept    = bus.P_VALID && p_ready;
        p_ext     = bus.P_SIGNED ? {{(ACC_W-32){bus.P_IN[31]}}, bus.P_IN}
                                 : {{(ACC_W-32){1'b0}}, bus.P_IN};
        // One guard bit: the top two bits disagree exactly when the signed add overflowed.
        sum_wide  = {acc_q[ACC_W-1], acc_q} + {s1_q[ACC_W-1], s1_q};

        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        s1_d      = s1_q;
        s1_last_d = s1_last_q;
        s1_v_d    = 1'b0;

        if (accept) begin
            s1_d      = p_ext;
            s1_last_d = bus.P_LAST;
            s1_v_d    = 1'b1;
        end

        if (s1_v_q) begin
            if (sum_wide[ACC_W] == sum_wide[ACC_W-1]) begin
                acc_d = sum_wide[ACC_W-1:0];
            end else if (!sum_wide[ACC_W]) begin
                acc_d = ACC_MAX;
                ovf_d = 1'b1;
            end else begin
                acc_d = ACC_MIN;
                ovf_d = 1'b1;
            end
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        case (state_q)
            ACCUM: if (accept && bus.P_LAST) state_d = FLUSH;
            FLUSH: if (s1_v_q && s1_last_q) state_d = DONE;
            DONE: begin
                if (bus.SUM_READY) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = ACCUM;
                end
            end
            default: state_d = ACCUM;
        endcase

        // Abort wins over everything, including a result transfer in the same cycle.
        if (bus.CLR) begin
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
            s1_v_d  = 1'b0;
            state_d = ACCUM;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= ACCUM;
            acc_q     <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            s1_q      <= '0;
            s1_last_q <= 1'b0;
            s1_v_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            s1_q      <= s1_d;
            s1_last_q <= s1_last_d;
            s1_v_q    <= s1_v_d;
        end
    end

    assign bus.P_READY   = p_ready;
    assign bus.SUM       = acc_q;
    assign bus.SUM_COUNT = cnt_q;
    assign bus.SUM_OVF   = ovf_q;
    assign bus.SUM_VALID = (state_q == DONE);
endmodule
